// File: rtl/wb_arbiter.sv
// wb_arbiter: grants completed unit results onto the two
// register-file write ports with round-robin priority.
module wb_arbiter #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu1_done,
  input  logic [5:0]        alu1_rn,
  input  logic [DATA_W-1:0] alu1_data,
  input  logic              alu2_done,
  input  logic [5:0]        alu2_rn,
  input  logic [DATA_W-1:0] alu2_data,
  input  logic              adv_done,
  input  logic [5:0]        adv_rn,
  input  logic [5:0]        adv_rn2,
  input  logic [DATA_W-1:0] adv_data,
  input  logic [DATA_W-1:0] adv_data2,
  input  logic              mem_done,
  input  logic [5:0]        mem_rn,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              br_done,
  input  logic [5:0]        br_rn,
  input  logic [DATA_W-1:0] br_data,
  output logic              alu1_ack,
  output logic              alu2_ack,
  output logic              adv_ack,
  output logic              mem_ack,
  output logic              br_ack,
  output logic              wr1_en,
  output logic [5:0]        wr1_rn,
  output logic [DATA_W-1:0] wr1_data,
  output logic              wr2_en,
  output logic [5:0]        wr2_rn,
  output logic [DATA_W-1:0] wr2_data,
  output logic [5:0]        reg1_finished,
  output logic [5:0]        reg2_finished
);

  logic [2:0]        ptr;
  logic [2:0]        ptr_nxt;
  logic [4:0]        done_v;
  logic [4:0]        zero_v;
  logic [4:0]        gnt;
  logic [5:0]        rn_v  [5];
  logic [DATA_W-1:0] dat_v [5];
  logic              adv_dual;
  logic [3:0]        pos;
  logic [2:0]        idx;
  logic              e1_n;
  logic              e2_n;
  logic [5:0]        r1_n;
  logic [5:0]        r2_n;
  logic [DATA_W-1:0] d1_n;
  logic [DATA_W-1:0] d2_n;

  // Gather sources by index; a single-field advint uses its nonzero pair.
  always_comb begin
    done_v   = {br_done, mem_done, adv_done, alu2_done, alu1_done};
    adv_dual = (adv_rn != 6'd0) && (adv_rn2 != 6'd0);
    rn_v[0]  = alu1_rn;
    rn_v[1]  = alu2_rn;
    rn_v[2]  = (adv_rn != 6'd0) ? adv_rn : adv_rn2;
    rn_v[3]  = mem_rn;
    rn_v[4]  = br_rn;
    dat_v[0] = alu1_data;
    dat_v[1] = alu2_data;
    dat_v[2] = (adv_rn != 6'd0) ? adv_data : adv_data2;
    dat_v[3] = mem_data;
    dat_v[4] = br_data;
    for (int i = 0; i < 5; i++) begin
      zero_v[i] = (rn_v[i] == 6'd0);
    end
  end

  // Scan from ptr, fill port 1 then port 2; rn-0 results ack for free.
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    pos     = '0;
    idx     = '0;
    e1_n    = 1'b0;
    e2_n    = 1'b0;
    r1_n    = '0;
    r2_n    = '0;
    d1_n    = '0;
    d2_n    = '0;
    for (int k = 0; k < 5; k++) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos > 4'd4) pos = pos - 4'd5;
      idx = pos[2:0];
      if (done_v[idx]) begin
        if (zero_v[idx]) begin
          gnt[idx] = 1'b1;
        end else if (idx == 3'd2 && adv_dual) begin
          if (!e1_n) begin
            gnt[idx] = 1'b1;
            e1_n     = 1'b1;
            r1_n     = adv_rn;
            d1_n     = adv_data;
            e2_n     = 1'b1;
            r2_n     = adv_rn2;
            d2_n     = adv_data2;
            ptr_nxt  = 3'd3;
          end
        end else if (!e1_n) begin
          gnt[idx] = 1'b1;
          e1_n     = 1'b1;
          r1_n     = rn_v[idx];
          d1_n     = dat_v[idx];
          ptr_nxt  = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end else if (!e2_n) begin
          gnt[idx] = 1'b1;
          e2_n     = 1'b1;
          r2_n     = rn_v[idx];
          d2_n     = dat_v[idx];
          ptr_nxt  = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
      end
    end
  end

  // Acks are suppressed while reset is held.
  always_comb begin
    alu1_ack = gnt[0] & rst_n;
    alu2_ack = gnt[1] & rst_n;
    adv_ack  = gnt[2] & rst_n;
    mem_ack  = gnt[3] & rst_n;
    br_ack   = gnt[4] & rst_n;
  end

  // Register this cycle's grants onto the write ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= 3'd0;
      wr1_en        <= 1'b0;
      wr1_rn        <= '0;
      wr1_data      <= '0;
      wr2_en        <= 1'b0;
      wr2_rn        <= '0;
      wr2_data      <= '0;
      reg1_finished <= '0;
      reg2_finished <= '0;
    end else begin
      ptr           <= ptr_nxt;
      wr1_en        <= e1_n;
      wr1_rn        <= r1_n;
      wr1_data      <= d1_n;
      wr2_en        <= e2_n;
      wr2_rn        <= r2_n;
      wr2_data      <= d2_n;
      reg1_finished <= e1_n ? r1_n : 6'd0;
      reg2_finished <= e2_n ? r2_n : 6'd0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for the writeback arbiter.
// Expected writes are queued at grant time, checked a cycle later.
module tb_wb_arbiter;

  typedef struct packed {
    logic        e1;
    logic [5:0]  r1;
    logic [63:0] d1;
    logic [5:0]  f1;
    logic        e2;
    logic [5:0]  r2;
    logic [63:0] d2;
    logic [5:0]  f2;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alu1_done = 0, alu2_done = 0, adv_done = 0, mem_done = 0, br_done = 0;
  logic [5:0] alu1_rn = 0, alu2_rn = 0, adv_rn = 0, adv_rn2 = 0;
  logic [5:0] mem_rn = 0, br_rn = 0;
  logic [63:0] alu1_data = 0, alu2_data = 0, adv_data = 0, adv_data2 = 0;
  logic [63:0] mem_data = 0, br_data = 0;
  logic alu1_ack, alu2_ack, adv_ack, mem_ack, br_ack;
  logic wr1_en, wr2_en;
  logic [5:0] wr1_rn, wr2_rn, reg1_finished, reg2_finished;
  logic [63:0] wr1_data, wr2_data;

  int n_cmp = 0;
  int n_bad = 0;
  wr_t sb[$];
  wr_t e;

  always #5 clk = ~clk;

  wb_arbiter #(.DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu1_done(alu1_done), .alu1_rn(alu1_rn), .alu1_data(alu1_data),
    .alu2_done(alu2_done), .alu2_rn(alu2_rn), .alu2_data(alu2_data),
    .adv_done(adv_done), .adv_rn(adv_rn), .adv_rn2(adv_rn2),
    .adv_data(adv_data), .adv_data2(adv_data2),
    .mem_done(mem_done), .mem_rn(mem_rn), .mem_data(mem_data),
    .br_done(br_done), .br_rn(br_rn), .br_data(br_data),
    .alu1_ack(alu1_ack), .alu2_ack(alu2_ack), .adv_ack(adv_ack),
    .mem_ack(mem_ack), .br_ack(br_ack),
    .wr1_en(wr1_en), .wr1_rn(wr1_rn), .wr1_data(wr1_data),
    .wr2_en(wr2_en), .wr2_rn(wr2_rn), .wr2_data(wr2_data),
    .reg1_finished(reg1_finished), .reg2_finished(reg2_finished)
  );

  function automatic wr_t mk(input logic e1, input logic [5:0] r1,
                             input logic [63:0] d1, input logic e2,
                             input logic [5:0] r2, input logic [63:0] d2);
    wr_t w;
    w.e1 = e1; w.r1 = r1; w.d1 = d1; w.f1 = e1 ? r1 : 6'd0;
    w.e2 = e2; w.r2 = r2; w.d2 = d2; w.f2 = e2 ? r2 : 6'd0;
    return w;
  endfunction

  function automatic wr_t obs();
    wr_t w;
    w.e1 = wr1_en; w.r1 = wr1_rn; w.d1 = wr1_data; w.f1 = reg1_finished;
    w.e2 = wr2_en; w.r2 = wr2_rn; w.d2 = wr2_data; w.f2 = reg2_finished;
    return w;
  endfunction

  function automatic logic [4:0] acks();
    return {br_ack, mem_ack, adv_ack, alu2_ack, alu1_ack};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    alu1_done = 0; alu2_done = 0; adv_done = 0; mem_done = 0; br_done = 0;
  endtask

  task automatic drop(input logic [4:0] a);
    if (a[0]) alu1_done = 0;
    if (a[1]) alu2_done = 0;
    if (a[2]) adv_done = 0;
    if (a[3]) mem_done = 0;
    if (a[4]) br_done = 0;
  endtask

  task automatic test_reset();
    alu1_done = 1; alu1_rn = 6'd5; alu1_data = 64'hAA;
    #2;
    n_cmp++;
    if (acks() !== 5'b0) begin
      n_bad++; $display("FAIL rst_ack got %b want 00000", acks());
    end
    n_cmp++;
    if (obs() !== mk(0, 0, 0, 0, 0, 0)) begin
      n_bad++; $display("FAIL rst_out got %h want 0", obs());
    end
    n_cmp++;
    if (dut.ptr !== 3'd0) begin
      n_bad++; $display("FAIL rst_ptr got %0d want 0", dut.ptr);
    end
    clear_in();
    tick();
    rst_n = 1;
  endtask

  task automatic test_idle();
    #1;
    n_cmp++;
    if (acks() !== 5'b0) begin
      n_bad++; $display("FAIL idle_ack got %b want 00000", acks());
    end
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    tick();
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++; $display("FAIL idle_wr got %h want %h", obs(), e);
    end
  endtask

  task automatic test_single();
    alu1_done = 1; alu1_rn = 6'd5; alu1_data = 64'hAA;
    #1;
    n_cmp++;
    if (acks() !== 5'b00001) begin
      n_bad++; $display("FAIL single_ack got %b want 00001", acks());
    end
    sb.push_back(mk(1, 5, 64'hAA, 0, 0, 0));
    tick();
    drop(5'b00001);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++; $display("FAIL single_wr got %h want %h", obs(), e);
    end
    n_cmp++;
    if (dut.ptr !== 3'd1) begin
      n_bad++; $display("FAIL single_ptr got %0d want 1", dut.ptr);
    end
  endtask

  task automatic test_all_five();
    logic [4:0] ea [3];
    wr_t ew [3];
    ea = '{5'b00011, 5'b01100, 5'b10000};
    ew[0] = mk(1, 1, 64'h101, 1, 2, 64'h102);
    ew[1] = mk(1, 3, 64'h103, 1, 4, 64'h104);
    ew[2] = mk(1, 5, 64'h105, 0, 0, 0);
    rst_n = 0;
    tick();
    rst_n = 1;
    alu1_done = 1; alu1_rn = 1; alu1_data = 64'h101;
    alu2_done = 1; alu2_rn = 2; alu2_data = 64'h102;
    adv_done = 1; adv_rn = 3; adv_rn2 = 0; adv_data = 64'h103;
    adv_data2 = 64'hBAD;
    mem_done = 1; mem_rn = 4; mem_data = 64'h104;
    br_done = 1; br_rn = 5; br_data = 64'h105;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (acks() !== ea[c]) begin
        n_bad++;
        $display("FAIL all5_ack%0d got %b want %b", c, acks(), ea[c]);
      end
      sb.push_back(ew[c]);
      tick();
      drop(ea[c]);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++; $display("FAIL all5_wr%0d got %h want %h", c, obs(), e);
      end
      if (c == 0) begin
        n_cmp++;
        if (dut.ptr !== 3'd2) begin
          n_bad++; $display("FAIL all5_ptr got %0d want 2", dut.ptr);
        end
      end
    end
  endtask

  task automatic test_dual_adv();
    alu1_done = 1; alu1_rn = 7; alu1_data = 64'h707;
    adv_done = 1; adv_rn = 10; adv_rn2 = 11;
    adv_data = 64'hA10; adv_data2 = 64'hA11;
    #1;
    n_cmp++;
    if (acks() !== 5'b00001) begin
      n_bad++; $display("FAIL dual_ack1 got %b want 00001", acks());
    end
    sb.push_back(mk(1, 7, 64'h707, 0, 0, 0));
    tick();
    drop(5'b00001);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++; $display("FAIL dual_wr1 got %h want %h", obs(), e);
    end
    #1;
    n_cmp++;
    if (acks() !== 5'b00100) begin
      n_bad++; $display("FAIL dual_ack2 got %b want 00100", acks());
    end
    sb.push_back(mk(1, 10, 64'hA10, 1, 11, 64'hA11));
    tick();
    drop(5'b00100);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++; $display("FAIL dual_wr2 got %h want %h", obs(), e);
    end
    n_cmp++;
    if (dut.ptr !== 3'd3) begin
      n_bad++; $display("FAIL dual_ptr got %0d want 3", dut.ptr);
    end
  endtask

  task automatic test_rn0_discard();
    br_done = 1; br_rn = 0; br_data = 64'hDEAD;
    alu1_done = 1; alu1_rn = 3; alu1_data = 64'h303;
    alu2_done = 1; alu2_rn = 4; alu2_data = 64'h404;
    adv_done = 1; adv_rn = 0; adv_rn2 = 0;
    #1;
    n_cmp++;
    if (acks() !== 5'b10111) begin
      n_bad++; $display("FAIL rn0_ack got %b want 10111", acks());
    end
    sb.push_back(mk(1, 3, 64'h303, 1, 4, 64'h404));
    tick();
    drop(5'b10111);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++; $display("FAIL rn0_wr got %h want %h", obs(), e);
    end
    n_cmp++;
    if (dut.ptr !== 3'd2) begin
      n_bad++; $display("FAIL rn0_ptr got %0d want 2", dut.ptr);
    end
  endtask

  task automatic test_starvation();
    adv_done = 1; adv_rn = 0; adv_rn2 = 21;
    adv_data = 64'hDEAD; adv_data2 = 64'h2121;
    #1;
    n_cmp++;
    if (acks() !== 5'b00100) begin
      n_bad++; $display("FAIL adv2_ack got %b want 00100", acks());
    end
    sb.push_back(mk(1, 21, 64'h2121, 0, 0, 0));
    tick();
    drop(5'b00100);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++; $display("FAIL adv2_wr got %h want %h", obs(), e);
    end
    for (int c = 0; c < 3; c++) begin
      mem_done = 1; mem_rn = 6'(30 + c); mem_data = 64'(32'h3000 + c);
      br_done = 1; br_rn = 6'(40 + c); br_data = 64'(32'h4000 + c);
      #1;
      n_cmp++;
      if (acks() !== 5'b11000) begin
        n_bad++; $display("FAIL starve_ack%0d got %b want 11000", c, acks());
      end
      sb.push_back(mk(1, 6'(30 + c), 64'(32'h3000 + c),
                      1, 6'(40 + c), 64'(32'h4000 + c)));
      tick();
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++; $display("FAIL starve_wr%0d got %h want %h", c, obs(), e);
      end
    end
    clear_in();
  endtask

  task automatic test_reset_mid();
    alu1_done = 1; alu1_rn = 6; alu1_data = 64'h606;
    #1;
    sb.push_back(mk(1, 6, 64'h606, 0, 0, 0));
    tick();
    drop(5'b00001);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++; $display("FAIL mid_wr got %h want %h", obs(), e);
    end
    alu2_done = 1; alu2_rn = 8;
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if (obs() !== mk(0, 0, 0, 0, 0, 0)) begin
      n_bad++; $display("FAIL mid_out got %h want 0", obs());
    end
    n_cmp++;
    if (dut.ptr !== 3'd0) begin
      n_bad++; $display("FAIL mid_ptr got %0d want 0", dut.ptr);
    end
    n_cmp++;
    if (acks() !== 5'b0) begin
      n_bad++; $display("FAIL mid_ack got %b want 00000", acks());
    end
    clear_in();
    tick();
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_all_five();
    test_dual_adv();
    test_rn0_discard();
    test_starvation();
    test_idle();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL sb_left got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
